instr_fetch_unit: RTL

Instruction fetch stage for the single-cycle RISC-V core. Holds the program counter and issues word fetches to instruction memory over a req/ack handshake. Presents each fetched 32-bit instruction and its PC to decode/control through a valid/ready handshake. Accepts branch/jump redirects from the execute path.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter plus the shadow target used while a squashed request drains.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        incr,
  input  logic        load,
  input  logic        shadow_wr,
  input  logic        consume,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        drop
);

  logic [31:0] pc_reg;
  logic [31:0] shadow_reg;
  logic        drop_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      shadow_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (load)
        pc_reg <= target;
      else if (consume)
        pc_reg <= shadow_reg;
      else if (incr)
        pc_reg <= pc_reg + INSTR_BYTES;  // wraps modulo 2^32

      // A newer redirect simply overwrites the pending target.
      if (shadow_wr) begin
        shadow_reg <= target;
        drop_reg   <= 1'b1;
      end else if (load || consume) begin
        drop_reg   <= 1'b0;
      end
    end
  end

  assign pc   = pc_reg;
  assign drop = drop_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: req/ack word fetches from imem, valid/ready hand-off to decode, redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned_fault
);

  fetch_state_t state_reg;
  logic         valid_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  instr_pc_reg;
  logic         fault_reg;

  logic [31:0]  pc;
  logic         drop;
  logic         in_fetch;
  logic         fetch_ack;
  logic         redir_ok;
  logic         redir_bad;
  logic         pc_load;
  logic         shadow_wr;
  logic         consume;
  logic         incr;

  assign in_fetch  = (state_reg == FETCH);
  assign fetch_ack = in_fetch && imem_ack;
  assign redir_ok  = (state_reg != FAULT) && redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = (state_reg != FAULT) && redirect && (redirect_pc[1:0] != 2'b00);

  // pc may only move once the outstanding request (if any) has been acked.
  assign pc_load   = redir_ok && (!in_fetch || imem_ack);
  assign shadow_wr = redir_ok && in_fetch && !imem_ack;
  assign consume   = fetch_ack && !redirect && drop;
  assign incr      = fetch_ack && !redirect && !drop;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .incr      (incr),
    .load      (pc_load),
    .shadow_wr (shadow_wr),
    .consume   (consume),
    .target    (redirect_pc),
    .pc        (pc),
    .drop      (drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      valid_reg    <= 1'b0;
      instr_reg    <= NOP_INSTR;
      instr_pc_reg <= '0;
      fault_reg    <= 1'b0;
    end else if (redir_bad) begin
      state_reg <= FAULT;
      valid_reg <= 1'b0;
      fault_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH: begin
          if (incr) begin
            instr_reg    <= imem_rdata;
            instr_pc_reg <= pc;
            valid_reg    <= 1'b1;
            state_reg    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            valid_reg <= 1'b0;
            state_reg <= FETCH;
          end
        end
        FAULT: begin
          state_reg <= FAULT;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req         = in_fetch;
  assign imem_addr        = pc;
  assign instr_valid      = valid_reg;
  assign instr            = instr_reg;
  assign instr_pc         = instr_pc_reg;
  assign misaligned_fault = fault_reg;

endmodule
